// File: rtl/array_result_tx.sv
// AXI-Stream transmitter that captures an N x N systolic-array result and streams it row-major.
// Optional macro TX_ROW_LAST_EN: assert m_axis_last at the end of every row instead of only at the end of the matrix.
module array_result_tx #(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  arr_C_valid,
    input  logic [N*N*DATA_W-1:0] arr_C_flat,
    input  logic                  m_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_W-1:0]     m_axis_data,
    output logic                  m_axis_last,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_overrun
);

    localparam int ELEMS = N * N;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ELEMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [ELEMS*DATA_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]        idx_nxt;

    function automatic logic last_at(input logic [IDX_W-1:0] i);
`ifdef TX_ROW_LAST_EN
        return (int'(i) % N) == (N - 1);
`else
        return i == IDX_MAX;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hold_d    = hold_q;
        idx_nxt   = idx_q + 1'b1;
        // A new result arriving while a matrix is still in flight is dropped and flagged.
        overrun_d = overrun_q | (arr_C_valid && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (arr_C_valid) begin
                    hold_d  = arr_C_flat;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = arr_C_flat[DATA_W-1:0];
                    last_d  = last_at('0);
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (valid_q && m_axis_ready) begin
                    if (idx_q == IDX_MAX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = hold_q[idx_nxt*DATA_W +: DATA_W];
                        last_d = last_at(idx_nxt);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Holding register content is meaningless until a capture, so it carries no reset.
    always_ff @(posedge i_clk) begin
        hold_q <= hold_d;
    end

    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign m_axis_last  = last_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_overrun   = overrun_q;

endmodule
